// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: hex/blank/minus decode or raw segment bits.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits in pattern mode.
module seg7_scan_driver #(
    parameter int unsigned SCAN_N = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_mode,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    logic [SCAN_N-1:0] cnt_q, cnt_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic [1:0]        sel;
    logic [7:0]        v;
    logic              supp;

    function automatic logic [6:0] hex_glyph(input logic [4:0] c);
        logic [6:0] g;
        g = 7'h7F;
        case (c)
            5'h00: g = 7'h40;
            5'h01: g = 7'h79;
            5'h02: g = 7'h24;
            5'h03: g = 7'h30;
            5'h04: g = 7'h19;
            5'h05: g = 7'h12;
            5'h06: g = 7'h02;
            5'h07: g = 7'h78;
            5'h08: g = 7'h00;
            5'h09: g = 7'h10;
            5'h0A: g = 7'h08;
            5'h0B: g = 7'h03;
            5'h0C: g = 7'h46;
            5'h0D: g = 7'h21;
            5'h0E: g = 7'h06;
            5'h0F: g = 7'h0E;
            5'h11: g = 7'h3F;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic is_blank_code(input logic [4:0] c);
        return (c == 5'h10) || (c >= 5'h12);
    endfunction

    logic supp3, supp2, supp1;

    // A zero is suppressed only when every digit to its left is dark.
    always_comb begin
        supp3 = (d3[4:0] == 5'h00);
        supp2 = (d2[4:0] == 5'h00) && (supp3 || is_blank_code(d3[4:0]));
        supp1 = (d1[4:0] == 5'h00) && (supp2 || is_blank_code(d2[4:0]));
    end
`endif

    assign sel = cnt_q[SCAN_N-1:SCAN_N-2];

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        v     = d0;
        supp  = 1'b0;
        case (sel)
            2'd0: v = d0;
            2'd1: v = d1;
            2'd2: v = d2;
            default: v = d3;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (sel)
            2'd1: supp = supp1;
            2'd2: supp = supp2;
            2'd3: supp = supp3;
            default: supp = 1'b0;
        endcase
`endif
        if (raw_mode) begin
            seg_d = ~v[6:0];
        end else if (supp) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = hex_glyph(v[4:0]);
        end
        dp_d = ~v[7];
        an_d = ~(4'b0001 << sel);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= 4'b1111;
        end else begin
            cnt_q <= cnt_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed cases plus randomized traffic against
// a table-driven model of the display. Honours LEADING_ZERO_BLANK_EN like the design.
module tb_seg7_scan_driver;

    localparam int unsigned SCAN_N = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       raw_mode = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_tests = 0;
    int n_fail  = 0;
    int cycles  = 0;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_an;

    seg7_scan_driver #(.SCAN_N(SCAN_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_mode (raw_mode),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycles);
        end
    endtask

    function automatic logic code_is_blank(input logic [4:0] c);
        return (c == 5'h10) || (c >= 5'h12);
    endfunction

    // Expected display for digit idx given the full set of inputs.
    task automatic model(input int idx, output logic [6:0] s, output logic p, output logic [3:0] a);
        logic [7:0] dig [4];
        logic [4:0] c;
        logic       supp [4];
        logic       dark;
        dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
        for (int k = 0; k < 4; k++) supp[k] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        dark = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            supp[k] = (dig[k][4:0] == 5'h00) && dark;
            dark    = supp[k] || code_is_blank(dig[k][4:0]);
        end
`else
        dark = 1'b0;
`endif
        c = dig[idx][4:0];
        if (raw_mode)       s = ~dig[idx][6:0];
        else if (supp[idx]) s = 7'h7F;
        else if (c < 5'h10) s = GLYPH[c[3:0]];
        else if (c == 5'h11) s = 7'h3F;
        else                s = 7'h7F;
        p = ~dig[idx][7];
        a = 4'b1111;
        a[idx] = 1'b0;
    endtask

    // One clock: predict at the edge from the inputs present, compare on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model((cycles >> (SCAN_N - 2)) % 4, exp_seg, exp_dp, exp_an);
        cycles++;
        @(negedge clk);
        check({tag, ".an"}, {8'h0, an}, {8'h0, exp_an});
        check({tag, ".seg"}, {5'h0, seg}, {5'h0, exp_seg});
        check({tag, ".dp"}, {11'h0, dp}, {11'h0, exp_dp});
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset  = 1'b0;
        cycles = 0;
    endtask

    function automatic logic [7:0] rand_digit();
        logic [7:0] v;
        v = 8'($urandom);
        case ($urandom_range(0, 3))
            0: v[4:0] = 5'h00;
            1: v[4:0] = 5'($urandom_range(16, 17));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dark", {an, dp, seg}, {4'b1111, 1'b1, 7'h7F});

        release_reset();
        step("first");
        check("first_digit0", {8'h0, an}, 12'h00E);
        for (int i = 0; i < 31; i++) step("scan");

        // Pattern mode hex, dp and blank code.
        d0 = 8'h01; d1 = 8'h0A; d2 = 8'h8F; d3 = 8'h10;
        for (int i = 0; i < 16; i++) step("pat_hex");

        d3 = 8'h11; d2 = 8'h13;
        for (int i = 0; i < 16; i++) step("pat_minus");

        raw_mode = 1'b1; d0 = 8'h81; d1 = 8'h7F;
        for (int i = 0; i < 16; i++) step("raw");

        // Toggle raw_mode while digit 0 holds 0x08.
        raw_mode = 1'b0; d0 = 8'h08;
        while (((cycles >> (SCAN_N - 2)) % 4) != 0) step("align");
        step("tog_pat");
        check("tog_pat_seg", {5'h0, seg}, 12'h000);
        raw_mode = 1'b1;
        step("tog_raw");
        check("tog_raw_seg", {5'h0, seg}, 12'h077);
        check("tog_raw_an", {8'h0, an}, 12'h00E);

        raw_mode = 1'b0; d3 = 8'h00; d2 = 8'h00; d1 = 8'h05; d0 = 8'h00;
        for (int i = 0; i < 16; i++) step("lzb");

        // Randomized traffic with occasional mid-scan resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                d0 = rand_digit(); d1 = rand_digit(); d2 = rand_digit(); d3 = rand_digit();
            end
            if ($urandom_range(0, 7) == 0) raw_mode = ~raw_mode;
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                #1 check("mid_reset_dark", {an, dp, seg}, {4'b1111, 1'b1, 7'h7F});
                release_reset();
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives the Basys3 four-digit, common-anode 7-segment display from four 8-bit digit registers plus a mode select.
- An internal prescaler counter time-multiplexes the digits.
- Each digit is shown either as a decoded hex/blank/minus pattern or as raw segment bits.
- Sits below the memory-mapped basic I/O block, which owns the digit and control registers.

Parameters:
- SCAN_N, 18, prescaler counter width. The digit index is counter[SCAN_N-1:SCAN_N-2], so each digit is lit for 2^(SCAN_N-2) clocks. Legal values are 3 to 24.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- raw_mode  in  1  0 = pattern decode, 1 = raw segment bits
- d0  in  8  rightmost digit (an[0])
- d1  in  8  digit on an[1]
- d2  in  8  digit on an[2]
- d3  in  8  leftmost digit (an[3])
- seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low
- an  out  4  digit anodes, active-low, one-hot-low while scanning

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state: prescaler counter = 0, an = 4'b1111, seg = 7'h7F, dp = 1 (all dark).
- Prescaler:
  - Free-running SCAN_N-bit up-counter, wraps from all-ones to 0.
  - sel = counter[SCAN_N-1:SCAN_N-2]; scan order is 0,1,2,3,0,…
- Output registers:
  - seg, dp and an are registered and update on every clk edge from the current sel and the current input value.
  - Latency is 1 clk from a change in the counter or an input to the outputs.
  - an = ~(4'b0001 << sel).
  - After reset release, the first rising edge produces an = 4'b1110 (digit 0).
- Pattern mode (raw_mode = 0), digit value v:
  - v[4:0] 0x00–0x0F: hex glyph. Active-low seg values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - v[4:0] = 0x10: blank (7F).
  - v[4:0] = 0x11: minus sign (3F).
  - v[4:0] 0x12–0x1F: blank (7F).
  - v[6:5] ignored.
  - dp = ~v[7].
- Raw mode (raw_mode = 1): seg[i] = ~v[i] for i = 0..6; dp = ~v[7].
- raw_mode may change at any time; it takes effect on the next output register update.
- Input changes mid-digit are shown from the next clock; no input latching is done.
- Reset asserted mid-scan immediately forces the dark reset state and restarts the scan at digit 0 after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined, in pattern mode only:
  - d3 with v[4:0] = 0x00 is blanked.
  - d2 with v[4:0] = 0x00 is blanked if d3 is blanked or is itself a blank code (0x10 or 0x12–0x1F).
  - d1 follows the same rule relative to d2.
  - d0 is never suppressed.
  - dp still follows v[7].
- When not defined, zeros are always displayed as glyph 0 (40).
- Raw mode is unaffected in both cases.

Test Plan:
- Reset, then release with SCAN_N = 4 and any inputs -> during reset an = 1111, seg = 7F, dp = 1; the next edge gives an = 1110, and an then cycles 1110→1101→1011→0111 every 4 clocks, repeating.
- Pattern mode, d0..d3 = 01, 0A, 8F, 10 -> on an[0]: seg = 79, dp = 1; an[1]: seg = 08, dp = 1; an[2]: seg = 0E, dp = 0; an[3]: seg = 7F.
- Pattern mode, d3 = 11, d2 = 13 -> an[3] shows seg = 3F; an[2] shows seg = 7F.
- Raw mode, d0 = 0x81, d1 = 0x7F -> on an[0]: seg = 7E, dp = 0; on an[1]: seg = 00, dp = 1.
- Toggle raw_mode while digit 0 = 0x08 is active -> seg goes from 00 (pattern) to 77 (raw) one clock after the toggle, with no anode change.
- With LEADING_ZERO_BLANK_EN, d3..d0 = 00, 00, 05, 00 -> an[3] and an[2] show 7F, an[1] shows 12, an[0] shows 40. Without the macro, an[3] and an[2] show 40.
